// File: rtl/cic_comb_decim_if.sv
// Sample stream bundle for the CIC comb/decimator: integrator-chain samples in,
// decimated comb results out. The master drives samples; the slave is the comb section.
interface cic_comb_decim_if #(
  parameter int unsigned w    = 10,
  parameter int unsigned wout = 10
);
  logic signed [w-1:0]    din;
  logic                   din_vld;
  logic signed [wout-1:0] dout;
  logic                   dout_vld;

  modport master (
    output din,
    output din_vld,
    input  dout,
    input  dout_vld
  );

  modport slave (
    input  din,
    input  din_vld,
    output dout,
    output dout_vld
  );
endinterface

// File: rtl/cic_comb_decim.sv
// Decimating comb section of a CIC chain. Keeps every r-th valid integrator sample,
// runs it through n_stg pipelined combs (differential delay m, modulo 2^w arithmetic)
// and narrows the result from w to wout bits.
// Optional macro CIC_COMB_ROUND_EN: round half-up with positive clamp instead of
// truncating the output. Latency is identical either way.
module cic_comb_decim #(
  parameter int unsigned w     = 10,
  parameter int unsigned wout  = 10,
  parameter int unsigned n_stg = 3,
  parameter int unsigned m     = 1,
  parameter int unsigned r     = 8
) (
  input logic             clk,
  input logic             rst,
  cic_comb_decim_if.slave bus
);

  // r = 1 still gets a 1-bit counter that simply never leaves 0.
  localparam int unsigned Cw = (r > 1) ? $clog2(r) : 1;
  localparam logic [Cw-1:0] CntMax = Cw'(r - 1);

  logic [Cw-1:0] cnt;
  logic          accept;

  // x[0] is the captured sample; x[i] is the registered result of comb stage i.
  logic [w-1:0] x [n_stg+1];
  logic         v [n_stg+1];

  logic [wout-1:0] red;
  logic [wout-1:0] dout_reg;
  logic            dout_vld_reg;

  assign accept = bus.din_vld && (cnt == CntMax);

  // Decimation counter: advances on valid input only, wraps on the accepted sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (bus.din_vld) begin
      if (cnt == CntMax) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + Cw'(1);
      end
    end
  end

  // Stage 0: capture the accepted sample and flag it for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x[0] <= '0;
      v[0] <= 1'b0;
    end else begin
      v[0] <= accept;
      if (accept) begin
        x[0] <= bus.din;
      end
    end
  end

  for (genvar i = 1; i <= int'(n_stg); i++) begin : g_comb
    // dly[k] holds the input of this stage k+1 accepted samples ago.
    logic [m-1:0][w-1:0] dly;

    // Comb stage: difference against the sample m valids back; wraps modulo 2^w.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dly  <= '0;
        x[i] <= '0;
        v[i] <= 1'b0;
      end else begin
        v[i] <= v[i-1];
        if (v[i-1]) begin
          x[i]   <= x[i-1] - dly[m-1];
          dly[0] <= x[i-1];
          for (int k = 1; k < int'(m); k++) begin
            dly[k] <= dly[k-1];
          end
        end
      end
    end
  end

`ifdef CIC_COMB_ROUND_EN
  if (w > wout) begin : g_round
    localparam int unsigned Sh = w - wout;
    localparam logic [w:0] Half = {{w{1'b0}}, 1'b1} << (Sh - 1);
    localparam logic [wout-1:0] MaxPos = {wout{1'b1}} >> 1;

    logic [w:0] sum;

    // Sign-extend to w+1 bits so adding the half-LSB cannot wrap silently.
    assign sum = {x[n_stg][w-1], x[n_stg]} + Half;

    // Overflow only happens upward: the sum stays non-negative but bit w-1 flipped.
    always_comb begin
      red = sum[w-1 -: wout];
      if (!sum[w] && sum[w-1]) begin
        red = MaxPos;
      end
    end
  end else begin : g_exact
    assign red = x[n_stg][w-1 -: wout];
  end
`else
  assign red = x[n_stg][w-1 -: wout];
`endif

  // Output register: strobe one cycle after the last comb, hold data between strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_reg     <= '0;
      dout_vld_reg <= 1'b0;
    end else begin
      dout_vld_reg <= v[n_stg];
      if (v[n_stg]) begin
        dout_reg <= red;
      end
    end
  end

  assign bus.dout     = dout_reg;
  assign bus.dout_vld = dout_vld_reg;

endmodule

// File: tb/tb_cic_comb_decim.sv
// Self-checking bench for cic_comb_decim. Five instances cover the different
// configurations; expected outputs come from constants or a binomial-sum model.
module tb_cic_comb_decim;

  localparam int NI = 5;
  // Per-instance configuration: a, b, c, d, e
  localparam int NS   [NI] = '{1, 1, 2, 3, 1};
  localparam int MD   [NI] = '{1, 1, 1, 2, 1};
  localparam int RR   [NI] = '{1, 4, 1, 2, 1};
  localparam int WO   [NI] = '{10, 10, 10, 10, 8};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  int obs_cyc [NI][$];
  int obs_val [NI][$];
  int exp_cyc [NI][$];
  int exp_val [NI][$];
  int hist    [NI][$];
  int vcnt    [NI];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cic_comb_decim_if #(.w(10), .wout(10)) bus_a ();
  cic_comb_decim_if #(.w(10), .wout(10)) bus_b ();
  cic_comb_decim_if #(.w(10), .wout(10)) bus_c ();
  cic_comb_decim_if #(.w(10), .wout(10)) bus_d ();
  cic_comb_decim_if #(.w(10), .wout(8))  bus_e ();

  cic_comb_decim #(.w(10), .wout(10), .n_stg(1), .m(1), .r(1))
    u_a (.clk(clk), .rst(rst), .bus(bus_a));
  cic_comb_decim #(.w(10), .wout(10), .n_stg(1), .m(1), .r(4))
    u_b (.clk(clk), .rst(rst), .bus(bus_b));
  cic_comb_decim #(.w(10), .wout(10), .n_stg(2), .m(1), .r(1))
    u_c (.clk(clk), .rst(rst), .bus(bus_c));
  cic_comb_decim #(.w(10), .wout(10), .n_stg(3), .m(2), .r(2))
    u_d (.clk(clk), .rst(rst), .bus(bus_d));
  cic_comb_decim #(.w(10), .wout(8), .n_stg(1), .m(1), .r(1))
    u_e (.clk(clk), .rst(rst), .bus(bus_e));

  // Record every output strobe with the cycle it was seen in.
  always @(negedge clk) begin
    if (bus_a.dout_vld) begin obs_cyc[0].push_back(cyc); obs_val[0].push_back(int'(bus_a.dout)); end
    if (bus_b.dout_vld) begin obs_cyc[1].push_back(cyc); obs_val[1].push_back(int'(bus_b.dout)); end
    if (bus_c.dout_vld) begin obs_cyc[2].push_back(cyc); obs_val[2].push_back(int'(bus_c.dout)); end
    if (bus_d.dout_vld) begin obs_cyc[3].push_back(cyc); obs_val[3].push_back(int'(bus_d.dout)); end
    if (bus_e.dout_vld) begin obs_cyc[4].push_back(cyc); obs_val[4].push_back(int'(bus_e.dout)); end
  end

  function automatic logic signed [31:0] get_dout(int k);
    case (k)
      0: return 32'(bus_a.dout);
      1: return 32'(bus_b.dout);
      2: return 32'(bus_c.dout);
      3: return 32'(bus_d.dout);
      default: return 32'(bus_e.dout);
    endcase
  endfunction

  function automatic logic get_vld(int k);
    case (k)
      0: return bus_a.dout_vld;
      1: return bus_b.dout_vld;
      2: return bus_c.dout_vld;
      3: return bus_d.dout_vld;
      default: return bus_e.dout_vld;
    endcase
  endfunction

  // n cascaded combs of delay m equal sum_t (-1)^t C(n,t) x[j - t*m], then wrap
  // to w=10 bits and reduce to wout bits.
  function automatic int comb_ref(int k);
    int j   = hist[k].size() - 1;
    int acc = 0;
    int c   = 1;
    int y;
    int sh  = 10 - WO[k];
    int res;
    for (int t = 0; t <= NS[k]; t++) begin
      int idx = j - t * MD[k];
      if (idx >= 0) acc += ((t % 2) != 0 ? -c : c) * hist[k][idx];
      c = c * (NS[k] - t) / (t + 1);
    end
    y = acc & 1023;
    if (y >= 512) y -= 1024;
`ifdef CIC_COMB_ROUND_EN
    if (sh > 0) begin
      res = (y + (1 << (sh - 1))) >>> sh;
      if (res > (1 << (WO[k] - 1)) - 1) res = (1 << (WO[k] - 1)) - 1;
    end else begin
      res = y;
    end
`else
    res = y >>> sh;
`endif
    return res;
  endfunction

  task automatic clear_model();
    for (int k = 0; k < NI; k++) begin
      obs_cyc[k].delete(); obs_val[k].delete();
      exp_cyc[k].delete(); exp_val[k].delete();
      hist[k].delete();
      vcnt[k] = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one input cycle on instance k and advance the reference model.
  task automatic drv(int k, bit vld, int x);
    case (k)
      0: begin bus_a.din = 10'(x); bus_a.din_vld = vld; end
      1: begin bus_b.din = 10'(x); bus_b.din_vld = vld; end
      2: begin bus_c.din = 10'(x); bus_c.din_vld = vld; end
      3: begin bus_d.din = 10'(x); bus_d.din_vld = vld; end
      default: begin bus_e.din = 10'(x); bus_e.din_vld = vld; end
    endcase
    if (vld) begin
      vcnt[k]++;
      if (vcnt[k] % RR[k] == 0) begin
        hist[k].push_back(x);
        exp_cyc[k].push_back(cyc + NS[k] + 2);
        exp_val[k].push_back(comb_ref(k));
      end
    end
  endtask

  task automatic idle_all();
    for (int k = 0; k < NI; k++) drv(k, 1'b0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_all();
    step();
    step();
    rst = 1'b0;
    clear_model();
  endtask

  task automatic test_reset();
    idle_all();
    step();
    step();
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (get_vld(k) !== 1'b0) begin
        failures++;
        $display("FAIL reset_vld inst=%0d got=%0b expected=0", k, get_vld(k));
      end
      checks++;
      if (get_dout(k) !== 0) begin
        failures++;
        $display("FAIL reset_dout inst=%0d got=%0d expected=0", k, get_dout(k));
      end
    end
    rst = 1'b0;
    clear_model();
  endtask

  task automatic test_step();
    int vals [5] = '{0, 5, 5, 5, 5};
    int expv [5] = '{0, 5, 0, 0, 0};
    int dc   [5];
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drv(0, 1'b1, vals[i]);
      dc[i] = cyc;
      step();
    end
    drv(0, 1'b0, 0);
    repeat (6) step();
    checks++;
    if (obs_val[0].size() !== 5) begin
      failures++;
      $display("FAIL step_count got=%0d expected=5", obs_val[0].size());
    end
    for (int i = 0; i < 5 && i < obs_val[0].size(); i++) begin
      checks++;
      if (obs_val[0][i] !== expv[i] || obs_cyc[0][i] !== dc[i] + 3) begin
        failures++;
        $display("FAIL step_out[%0d] got=%0d@%0d expected=%0d@%0d", i, obs_val[0][i],
                 obs_cyc[0][i], expv[i], dc[i] + 3);
      end
    end
  endtask

  // Runs straight after test_step: the last accepted sample of instance a is 5.
  task automatic test_wrap();
    int expv [2] = '{506, 1};
    obs_cyc[0].delete();
    obs_val[0].delete();
    drv(0, 1'b1, 511);
    step();
    drv(0, 1'b1, -512);
    step();
    drv(0, 1'b0, 0);
    repeat (5) step();
    checks++;
    if (obs_val[0].size() !== 2) begin
      failures++;
      $display("FAIL wrap_count got=%0d expected=2", obs_val[0].size());
    end
    for (int i = 0; i < 2 && i < obs_val[0].size(); i++) begin
      checks++;
      if (obs_val[0][i] !== expv[i]) begin
        failures++;
        $display("FAIL wrap_out[%0d] got=%0d expected=%0d", i, obs_val[0][i], expv[i]);
      end
    end
  endtask

  task automatic test_decim_gaps();
    int dc [$];
    do_reset();
    for (int i = 1; i <= 12; i++) begin
      drv(1, 1'b1, i);
      if (i % 4 == 0) dc.push_back(cyc);
      step();
      drv(1, 1'b0, 0);
      step();
    end
    repeat (6) step();
    checks++;
    if (obs_val[1].size() !== 3) begin
      failures++;
      $display("FAIL decim_count got=%0d expected=3", obs_val[1].size());
    end
    for (int i = 0; i < 3 && i < obs_val[1].size(); i++) begin
      checks++;
      if (obs_val[1][i] !== 4 || obs_cyc[1][i] !== dc[i] + 3) begin
        failures++;
        $display("FAIL decim_out[%0d] got=%0d@%0d expected=4@%0d", i, obs_val[1][i],
                 obs_cyc[1][i], dc[i] + 3);
      end
    end
  endtask

  // Two cascaded integrators feeding a 2-stage comb must reproduce the input.
  task automatic test_end_to_end();
    int src [4] = '{3, -7, 0, 100};
    int dc  [4];
    int i1 = 0;
    int i2 = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      i1 = (i1 + src[i]) & 1023;
      i2 = (i2 + i1) & 1023;
      drv(2, 1'b1, i2);
      dc[i] = cyc;
      step();
    end
    drv(2, 1'b0, 0);
    repeat (7) step();
    checks++;
    if (obs_val[2].size() !== 4) begin
      failures++;
      $display("FAIL e2e_count got=%0d expected=4", obs_val[2].size());
    end
    for (int i = 0; i < 4 && i < obs_val[2].size(); i++) begin
      checks++;
      if (obs_val[2][i] !== src[i] || obs_cyc[2][i] !== dc[i] + 4) begin
        failures++;
        $display("FAIL e2e_out[%0d] got=%0d@%0d expected=%0d@%0d", i, obs_val[2][i],
                 obs_cyc[2][i], src[i], dc[i] + 4);
      end
    end
  endtask

  task automatic test_mid_reset();
    int b  = $urandom_range(1, 500);
    int g  = -$urandom_range(1, 500);
    int dc;
    do_reset();
    drv(3, 1'b1, 17);
    step();
    drv(3, 1'b1, b);
    step();
    drv(3, 1'b0, 0);
    repeat (6) step();
    checks++;
    if (get_dout(3) !== b) begin
      failures++;
      $display("FAIL midrst_pre_dout got=%0d expected=%0d", get_dout(3), b);
    end
    // Second accepted sample goes in flight; hit reset while it sits in comb stage 1.
    drv(3, 1'b1, 33);
    step();
    drv(3, 1'b1, 44);
    step();
    drv(3, 1'b0, 0);
    step();
    rst = 1'b1;
    #1;
    checks++;
    if (get_vld(3) !== 1'b0 || get_dout(3) !== 0) begin
      failures++;
      $display("FAIL midrst_clear got=%0d/%0b expected=0/0", get_dout(3), get_vld(3));
    end
    clear_model();
    step();
    step();
    rst = 1'b0;
    repeat (8) step();
    checks++;
    if (obs_val[3].size() !== 0) begin
      failures++;
      $display("FAIL midrst_ghost got=%0d strobes expected=0", obs_val[3].size());
    end
    drv(3, 1'b1, 99);
    step();
    drv(3, 1'b0, 0);
    repeat (7) step();
    checks++;
    if (obs_val[3].size() !== 0) begin
      failures++;
      $display("FAIL midrst_first_valid got=%0d strobes expected=0", obs_val[3].size());
    end
    drv(3, 1'b1, g);
    dc = cyc;
    step();
    drv(3, 1'b0, 0);
    repeat (7) step();
    checks++;
    if (obs_val[3].size() !== 1) begin
      failures++;
      $display("FAIL midrst_second_count got=%0d expected=1", obs_val[3].size());
    end else begin
      checks++;
      if (obs_val[3][0] !== g || obs_cyc[3][0] !== dc + 5) begin
        failures++;
        $display("FAIL midrst_second_out got=%0d@%0d expected=%0d@%0d", obs_val[3][0],
                 obs_cyc[3][0], g, dc + 5);
      end
    end
  endtask

  task automatic test_round();
    int vals [4] = '{0, 6, 11, 522};
`ifdef CIC_COMB_ROUND_EN
    int expv [4] = '{0, 2, 1, 127};
`else
    int expv [4] = '{0, 1, 1, 127};
`endif
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drv(4, 1'b1, vals[i]);
      step();
    end
    drv(4, 1'b0, 0);
    repeat (5) step();
    checks++;
    if (obs_val[4].size() !== 4) begin
      failures++;
      $display("FAIL round_count got=%0d expected=4", obs_val[4].size());
    end
    for (int i = 0; i < 4 && i < obs_val[4].size(); i++) begin
      checks++;
      if (obs_val[4][i] !== expv[i]) begin
        failures++;
        $display("FAIL round_out[%0d] got=%0d expected=%0d", i, obs_val[4][i], expv[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 24; i++) begin
      drv(0, 1'b1, int'($urandom_range(0, 1023)) - 512);
      step();
    end
    drv(0, 1'b0, 0);
    repeat (5) step();
    checks++;
    if (obs_val[0].size() !== 24 || exp_val[0].size() !== 24) begin
      failures++;
      $display("FAIL b2b_count got=%0d expected=24", obs_val[0].size());
    end
    for (int i = 0; i < obs_val[0].size() && i < exp_val[0].size(); i++) begin
      checks++;
      if (obs_val[0][i] !== exp_val[0][i] || obs_cyc[0][i] !== exp_cyc[0][i]) begin
        failures++;
        $display("FAIL b2b_out[%0d] got=%0d@%0d expected=%0d@%0d", i, obs_val[0][i],
                 obs_cyc[0][i], exp_val[0][i], exp_cyc[0][i]);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 300; n++) begin
      for (int k = 0; k < NI; k++) begin
        drv(k, ($urandom_range(0, 99) < 60), int'($urandom_range(0, 1023)) - 512);
      end
      step();
    end
    idle_all();
    repeat (8) step();
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (obs_val[k].size() !== exp_val[k].size()) begin
        failures++;
        $display("FAIL rand_count inst=%0d got=%0d expected=%0d", k, obs_val[k].size(),
                 exp_val[k].size());
      end
      for (int i = 0; i < obs_val[k].size() && i < exp_val[k].size(); i++) begin
        checks++;
        if (obs_val[k][i] !== exp_val[k][i] || obs_cyc[k][i] !== exp_cyc[k][i]) begin
          failures++;
          $display("FAIL rand_out inst=%0d idx=%0d got=%0d@%0d expected=%0d@%0d", k, i,
                   obs_val[k][i], obs_cyc[k][i], exp_val[k][i], exp_cyc[k][i]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    #1;
    test_reset();
    test_step();
    test_wrap();
    test_decim_gaps();
    test_end_to_end();
    test_mid_reset();
    test_round();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
